// File: rtl/image_stream_seq.sv
// Frame sequencer feeding the BMP writer: WIDTH*DEPTH HSYNC bytes per frame.
// Optional line blanking is enabled with the IMG_SEQ_HBLANK_EN macro.
module image_stream_seq #(
  parameter int WIDTH   = 768,
  parameter int DEPTH   = 512,
  parameter int DATA_W  = 8,
  parameter int H_BLANK = 16
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     pix_valid,
  input  logic [DATA_W-1:0]        pix_data,
  output logic                     pix_ready,
  output logic                     HSYNC,
  output logic [DATA_W-1:0]        VGA_data,
  output logic [$clog2(DEPTH)-1:0] cur_row,
  output logic [$clog2(WIDTH)-1:0] cur_col,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int RW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH);

  if (WIDTH < 2) begin : g_bad_width
    $error("WIDTH must be >= 2");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("DEPTH must be >= 2");
  end
  if (H_BLANK < 1) begin : g_bad_hblank
    $error("H_BLANK must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    HBLANK,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [RW-1:0]       row_q, row_d;
  logic [CW-1:0]       col_q, col_d;
  logic                hsync_q, hsync_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                hs;
  logic                last_col;
  logic                last_row;

`ifdef IMG_SEQ_HBLANK_EN
  localparam int BW = $clog2(H_BLANK + 1);
  logic [BW-1:0]       blank_q, blank_d;
`endif

  assign pix_ready  = (state_q == ACTIVE);
  assign hs         = pix_valid & pix_ready;
  assign last_col   = (col_q == CW'(WIDTH - 1));
  assign last_row   = (row_q == RW'(DEPTH - 1));

  assign HSYNC      = hsync_q;
  assign VGA_data   = data_q;
  assign cur_row    = row_q;
  assign cur_col    = col_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

  // Next-state, counter and registered-output decode; abort overrides all.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    hsync_d = 1'b0;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef IMG_SEQ_HBLANK_EN
    blank_d = blank_q;
`endif
    if (abort) begin
      state_d = IDLE;
      row_d   = '0;
      col_d   = '0;
      busy_d  = 1'b0;
`ifdef IMG_SEQ_HBLANK_EN
      blank_d = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = ACTIVE;
            row_d   = '0;
            col_d   = '0;
            busy_d  = 1'b1;
          end
        end
        ACTIVE: begin
          if (hs) begin
            hsync_d = 1'b1;
            data_d  = pix_data;
            if (last_col) begin
              col_d = '0;
              if (last_row) begin
                row_d   = '0;
                state_d = DONE;
              end else begin
                row_d = row_q + RW'(1);
`ifdef IMG_SEQ_HBLANK_EN
                state_d = HBLANK;
                blank_d = '0;
`endif
              end
            end else begin
              col_d = col_q + CW'(1);
            end
          end
        end
`ifdef IMG_SEQ_HBLANK_EN
        HBLANK: begin
          if (blank_q == BW'(H_BLANK - 1)) begin
            state_d = ACTIVE;
            blank_d = '0;
          end else begin
            blank_d = blank_q + BW'(1);
          end
        end
`endif
        DONE: begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      hsync_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      hsync_q <= hsync_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef IMG_SEQ_HBLANK_EN
  // Line-blanking cycle counter.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      blank_q <= '0;
    end else begin
      blank_q <= blank_d;
    end
  end
`endif

endmodule

// File: tb/tb_image_stream_seq.sv
// Scoreboard bench for image_stream_seq (WIDTH=4, DEPTH=3, H_BLANK=2).
// Expectations follow IMG_SEQ_HBLANK_EN when the bundle is built with it.
module tb_image_stream_seq;

  localparam int W  = 4;
  localparam int D  = 3;
  localparam int HB = 2;
  localparam int DW = 8;
  localparam int N  = W * D;

  logic                 HCLK = 1'b0;
  logic                 HRESETn = 1'b1;
  logic                 start = 1'b0;
  logic                 abort = 1'b0;
  logic                 pix_valid = 1'b0;
  logic [DW-1:0]        pix_data = '0;
  logic                 pix_ready;
  logic                 HSYNC;
  logic [DW-1:0]        VGA_data;
  logic [$clog2(D)-1:0] cur_row;
  logic [$clog2(W)-1:0] cur_col;
  logic                 busy;
  logic                 frame_done;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    int            cyc;
    logic [DW-1:0] d;
  } exp_t;

  exp_t sb[$];

  always #5 HCLK = ~HCLK;

  image_stream_seq #(
    .WIDTH  (W),
    .DEPTH  (D),
    .DATA_W (DW),
    .H_BLANK(HB)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .start     (start),
    .abort     (abort),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_ready (pix_ready),
    .HSYNC     (HSYNC),
    .VGA_data  (VGA_data),
    .cur_row   (cur_row),
    .cur_col   (cur_col),
    .busy      (busy),
    .frame_done(frame_done)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit rdy_exp(input int c);
`ifdef IMG_SEQ_HBLANK_EN
    return (c >= 1 && c <= 4) || (c >= 7 && c <= 10) ||
           (c >= 13 && c <= 16);
`else
    return (c >= 1 && c <= 12);
`endif
  endfunction

  function automatic int done_exp();
`ifdef IMG_SEQ_HBLANK_EN
    return 18;
`else
    return 14;
`endif
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, pix_ready, 0);
    check({tag, "_hsync"}, HSYNC, 0);
    check({tag, "_fd"}, frame_done, 0);
  endtask

  // mode 0: pix_valid constant, mode 1: alternating 1/0
  task automatic run_frame(input int mode,
                           input int restart_c,
                           input int abort_c);
    int            cyc;
    int            acc;
    int            hs_cnt;
    int            last_hs;
    int            fd_cyc;
    bit            have_last;
    logic [DW-1:0] seed;
    logic [DW-1:0] last_d;
    exp_t          e;
    acc       = 0;
    hs_cnt    = 0;
    last_hs   = -1;
    fd_cyc    = -1;
    have_last = 1'b0;
    last_d    = '0;
    seed      = DW'($urandom_range(0, 200));
    sb.delete();
    @(posedge HCLK);
    #1;
    cyc       = 0;
    start     = 1'b1;
    abort     = 1'b0;
    pix_valid = 1'b0;
    @(negedge HCLK);
    check_idle("c0");
    forever begin
      @(posedge HCLK);
      cyc++;
      #1;
      start     = (cyc == restart_c);
      abort     = (cyc == abort_c);
      pix_valid = (mode == 0) ? 1'b1 : ((cyc % 2) == 1);
      pix_data  = pix_valid ? DW'(seed + DW'(acc)) : DW'($urandom);
      @(negedge HCLK);
      if (HSYNC) begin
        hs_cnt++;
        if (sb.size() == 0) begin
          check("hs_spurious", 1, 0);
        end else begin
          e = sb.pop_front();
          check("vga_data", VGA_data, e.d);
          check("latency", cyc, e.cyc + 1);
          last_d    = e.d;
          have_last = 1'b1;
        end
      end else if (have_last) begin
        check("vga_hold", VGA_data, last_d);
      end
      if (frame_done) begin
        if (fd_cyc < 0) fd_cyc = cyc;
        else check("fd_width", cyc, fd_cyc);
      end
      if (abort_c >= 0 && cyc > abort_c) begin
        check("abort_busy", busy, 0);
        check("abort_ready", pix_ready, 0);
        check("abort_hsync", HSYNC, 0);
        if (cyc == abort_c + 1) begin
          check("abort_row", cur_row, 0);
          check("abort_col", cur_col, 0);
        end
      end else begin
        check("busy", busy, fd_cyc < 0);
      end
      if (mode == 0 && abort_c < 0) begin
        check("pix_ready", pix_ready, rdy_exp(cyc));
      end
      if (pix_valid && pix_ready) begin
        check("cur_row", cur_row, acc / W);
        check("cur_col", cur_col, acc % W);
        if (cyc != abort_c) begin
          e.cyc = cyc;
          e.d   = pix_data;
          sb.push_back(e);
          acc++;
          last_hs = cyc;
        end
      end
      if (abort_c >= 0 && cyc >= abort_c + 4) break;
      if (abort_c < 0 && fd_cyc >= 0 && cyc >= fd_cyc + 2) break;
      if (cyc > 100) begin
        check("timeout", 1, 0);
        break;
      end
    end
    @(posedge HCLK);
    #1;
    start     = 1'b0;
    abort     = 1'b0;
    pix_valid = 1'b0;
    check("sb_empty", sb.size(), 0);
    if (abort_c >= 0) begin
      check("abort_no_fd", fd_cyc, -1);
    end else begin
      check("hs_count", hs_cnt, N);
      check("accepted", acc, N);
      check("fd_after_last", fd_cyc, last_hs + 2);
      if (mode == 0) check("fd_cycle", fd_cyc, done_exp());
    end
  endtask

  initial begin
    #1;
    HRESETn = 1'b0;
    #1;
    check_idle("rst");
    check("rst_row", cur_row, 0);
    check("rst_col", cur_col, 0);
    check("rst_vga", VGA_data, 0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);
    check_idle("post_rst");

    run_frame(0, -1, -1);
    run_frame(1, -1, -1);
    run_frame(0, 5, 7);
    run_frame(0, -1, -1);

    @(posedge HCLK);
    #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge HCLK);
    #1;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) begin
      @(negedge HCLK);
      check_idle("abort_start");
    end

    @(posedge HCLK);
    #1;
    start     = 1'b1;
    pix_valid = 1'b1;
    pix_data  = 8'h5a;
    @(posedge HCLK);
    #1;
    start = 1'b0;
    repeat (5) @(posedge HCLK);
    #1;
    HRESETn = 1'b0;
    #1;
    check_idle("mid_rst");
    check("mid_rst_row", cur_row, 0);
    check("mid_rst_col", cur_col, 0);
    check("mid_rst_vga", VGA_data, 0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (3) begin
      @(negedge HCLK);
      check_idle("rel_idle");
    end
    @(posedge HCLK);
    #1;
    pix_valid = 1'b0;

    run_frame(0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
